// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: opcodes, instruction fields and
// controller states.
package cpu_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_MOV  = 4'h6;
   localparam logic [3:0] OP_LDI  = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int OPC_HI = 7;
   localparam int OPC_LO = 4;
   localparam int RD_HI  = 3;
   localparam int RD_LO  = 2;
   localparam int RS_HI  = 1;
   localparam int RS_LO  = 0;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_FETCH_IMM,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

   // ADD through XOR are the only operations that touch carry/zero.
   function automatic logic sets_flags(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/alu8.sv
// 8-bit combinational ALU: result plus carry/borrow and zero for each opcode.
module alu8
   import cpu_pkg::*;
(
   input  logic [3:0] op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] result,
   output logic       carry,
   output logic       zero
);

   always_comb begin
      // NOTE: defaults first so no path through the case can infer a latch.
      result = 8'h00;
      carry  = 1'b0;
      case (op)
         OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_MOV:  result = b;
         default: result = 8'h00;
      endcase
      zero = (result == 8'h00);
   end

endmodule

// File: rtl/fetch_decode_unit.sv
// Multicycle fetch/decode/execute controller driving the 4x8 register file
// and the instruction-memory req/valid handshake.
module fetch_decode_unit
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pc_in,
   output logic [7:0] imem_addr,
   output logic       imem_req,
   input  logic [7:0] imem_data,
   input  logic       imem_valid,
   output logic [1:0] rf_read_addr1,
   output logic [1:0] rf_read_addr2,
   input  logic [7:0] rf_read_data1,
   input  logic [7:0] rf_read_data2,
   output logic       rf_write_enable,
   output logic [1:0] rf_write_addr,
   output logic [7:0] rf_write_data,
   output logic       pc_write_enable,
   output logic       carry_flag,
   output logic       zero_flag,
   output logic       halted
);

   state_t     state;
   logic [7:0] ir;
   logic [7:0] result;
   logic [3:0] opcode;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic       alu_zero;

   assign opcode = ir[OPC_HI:OPC_LO];

   alu8 u_alu (
      .op     (opcode),
      .a      (rf_read_data1),
      .b      (rf_read_data2),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= S_FETCH;
         ir              <= 8'h00;
         result          <= 8'h00;
         pc_write_enable <= 1'b0;
         rf_write_enable <= 1'b0;
         carry_flag      <= 1'b0;
         zero_flag       <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; strobes default low so each is a
         // single-cycle pulse in the state after the one that raised it.
         pc_write_enable <= 1'b0;
         rf_write_enable <= 1'b0;
         case (state)
            S_FETCH: begin
               if (imem_valid) begin
                  ir              <= imem_data;
                  pc_write_enable <= 1'b1;
                  state           <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_HALT: state <= S_HALT;
                  OP_LDI:  state <= S_FETCH_IMM;
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV:
                     state <= S_EXECUTE;
                  default: state <= S_FETCH;
               endcase
            end
            S_FETCH_IMM: begin
               if (imem_valid) begin
                  result          <= imem_data;
                  pc_write_enable <= 1'b1;
                  rf_write_enable <= 1'b1;
                  state           <= S_WRITEBACK;
               end
            end
            S_EXECUTE: begin
               result          <= alu_result;
               rf_write_enable <= 1'b1;
               if (sets_flags(opcode)) begin
                  carry_flag <= alu_carry;
                  zero_flag  <= alu_zero;
               end
               state <= S_WRITEBACK;
            end
            S_WRITEBACK: state <= S_FETCH;
            S_HALT:      state <= S_HALT;
            default:     state <= S_FETCH;
         endcase
      end
   end

   // Register-file addresses come straight from the latched IR.
   assign imem_req      = (state == S_FETCH) || (state == S_FETCH_IMM);
   assign imem_addr     = pc_in;
   assign rf_read_addr1 = ir[RD_HI:RD_LO];
   assign rf_read_addr2 = ir[RS_HI:RS_LO];
   assign rf_write_addr = ir[RD_HI:RD_LO];
   assign rf_write_data = result;
   assign halted        = (state == S_HALT);

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench: models the register file/PC and instruction memory around
// fetch_decode_unit and checks hand-computed results.
module tb_fetch_decode_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] pc_in, imem_addr, imem_data, rf_read_data1, rf_read_data2, rf_write_data;
   logic       imem_req, imem_valid, rf_write_enable, pc_write_enable;
   logic       carry_flag, zero_flag, halted;
   logic [1:0] rf_read_addr1, rf_read_addr2, rf_write_addr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_decode_unit dut (
      .clk             (clk),
      .reset           (reset),
      .pc_in           (pc_in),
      .imem_addr       (imem_addr),
      .imem_req        (imem_req),
      .imem_data       (imem_data),
      .imem_valid      (imem_valid),
      .rf_read_addr1   (rf_read_addr1),
      .rf_read_addr2   (rf_read_addr2),
      .rf_read_data1   (rf_read_data1),
      .rf_read_data2   (rf_read_data2),
      .rf_write_enable (rf_write_enable),
      .rf_write_addr   (rf_write_addr),
      .rf_write_data   (rf_write_data),
      .pc_write_enable (pc_write_enable),
      .carry_flag      (carry_flag),
      .zero_flag       (zero_flag),
      .halted          (halted)
   );

   // Environment: program memory with configurable wait states, register file, PC.
   logic [7:0] prog [256];
   logic [7:0] regs [4];
   logic [7:0] preset [4];
   logic       load_rf = 1'b0;
   logic       inject = 1'b0;
   int         wait_cfg = 0;
   int         wait_cnt;
   logic [7:0] pc;

   always @(posedge clk or posedge reset)
      if (reset) pc <= 8'h00;
      else if (pc_write_enable) pc <= pc + 8'd1;

   always @(posedge clk or posedge reset)
      if (reset) wait_cnt <= 0;
      else if (imem_req && imem_valid) wait_cnt <= 0;
      else if (imem_req) wait_cnt <= wait_cnt + 1;

   always @(posedge clk)
      if (load_rf) for (int i = 0; i < 4; i++) regs[i] <= preset[i];
      else if (rf_write_enable) regs[rf_write_addr] <= rf_write_data;

   assign pc_in         = pc;
   assign imem_valid    = (imem_req && (wait_cnt >= wait_cfg)) || inject;
   assign imem_data     = prog[imem_addr];
   assign rf_read_data1 = regs[rf_read_addr1];
   assign rf_read_data2 = regs[rf_read_addr2];

   // Event monitor, sampled on the falling edge.
   int         cyc, pc_pulses, wr_count, req_count, halt_cyc;
   logic [1:0] wr_addr_log [16];
   logic [7:0] wr_data_log [16];
   int         wr_cyc_log [16];

   always @(negedge clk) begin
      if (reset) begin
         cyc <= 0; pc_pulses <= 0; wr_count <= 0; req_count <= 0; halt_cyc <= -1;
      end else begin
         cyc <= cyc + 1;
         if (pc_write_enable) pc_pulses <= pc_pulses + 1;
         if (imem_req) req_count <= req_count + 1;
         if (halted && halt_cyc < 0) halt_cyc <= cyc;
         if (rf_write_enable && wr_count < 16) begin
            wr_addr_log[wr_count] <= rf_write_addr;
            wr_data_log[wr_count] <= rf_write_data;
            wr_cyc_log[wr_count]  <= cyc;
            wr_count <= wr_count + 1;
         end
      end
   end

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 8'hF0;
   endtask

   // Reset is released 2 time units after a rising edge; the next falling
   // edge is cycle 0 of the first FETCH.
   task automatic do_reset(input bit load);
      reset = 1'b1; inject = 1'b0; load_rf = load;
      @(posedge clk); #1;
      @(posedge clk); #1;
      load_rf = 1'b0;
      #1 reset = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int budget, input string name);
      int k = 0;
      while (wr_count < n && k < budget) begin
         @(negedge clk); #1; k++;
      end
      checks++;
      if (wr_count < n) begin
         failures++;
         $display("FAIL %s_timeout: writes=%0d required=%0d", name, wr_count, n);
      end
   endtask

   task automatic run_to_halt(input int budget, input string name);
      int k = 0;
      while (halted !== 1'b1 && k < budget) begin
         @(negedge clk); #1; k++;
      end
      checks++;
      if (halted !== 1'b1) begin
         failures++;
         $display("FAIL %s_halt_timeout: halted=%b required=1", name, halted);
      end
   endtask

   task automatic test_reset();
      clear_prog();
      wait_cfg = 0;
      reset = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({pc_write_enable, rf_write_enable, carry_flag, zero_flag, halted} !== 5'b0) begin
         failures++;
         $display("FAIL reset_strobes_flags: got %b required 00000",
                  {pc_write_enable, rf_write_enable, carry_flag, zero_flag, halted});
      end
      checks++;
      if ({rf_read_addr1, rf_read_addr2, rf_write_addr, rf_write_data} !== 14'h0) begin
         failures++;
         $display("FAIL reset_addr_data: got %h required 0",
                  {rf_read_addr1, rf_read_addr2, rf_write_addr, rf_write_data});
      end
      @(posedge clk); #2 reset = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
         failures++;
         $display("FAIL reset_first_fetch: req/addr=%b/%h required 1/00", imem_req, imem_addr);
      end
   endtask

   task automatic test_ldi_add();
      clear_prog();
      prog[0] = 8'h74; prog[1] = 8'hF0;   // LDI R1,0xF0
      prog[2] = 8'h78; prog[3] = 8'h20;   // LDI R2,0x20
      prog[4] = 8'h16;                    // ADD R1,R2
      do_reset(1'b0);
      wait_writes(3, 60, "ldi_add");
      checks++;
      if ({wr_addr_log[0], wr_data_log[0]} !== {2'd1, 8'hF0} || wr_cyc_log[0] != 3) begin
         failures++;
         $display("FAIL ldi_first_write: addr/data/cyc=%0d/%h/%0d required 1/f0/3",
                  wr_addr_log[0], wr_data_log[0], wr_cyc_log[0]);
      end
      checks++;
      if ({wr_addr_log[2], wr_data_log[2]} !== {2'd1, 8'h10} || wr_cyc_log[2] != 11) begin
         failures++;
         $display("FAIL add_write: addr/data/cyc=%0d/%h/%0d required 1/10/11",
                  wr_addr_log[2], wr_data_log[2], wr_cyc_log[2]);
      end
      checks++;
      if ({carry_flag, zero_flag} !== 2'b10) begin
         failures++;
         $display("FAIL add_flags: carry/zero=%b%b required 10", carry_flag, zero_flag);
      end
      checks++;
      if (pc_pulses != 5) begin
         failures++;
         $display("FAIL add_pc_pulses: got %0d required 5", pc_pulses);
      end
      run_to_halt(20, "ldi_add");
      checks++;
      if ({regs[1], regs[2]} !== 16'h1020 || pc_pulses != 6 || halt_cyc != 14) begin
         failures++;
         $display("FAIL ldi_add_final: r1r2=%h pulses=%0d halt_cyc=%0d required 1020/6/14",
                  {regs[1], regs[2]}, pc_pulses, halt_cyc);
      end
   endtask

   task automatic test_reset_mid_wb();
      clear_prog();
      prog[0] = 8'h74; prog[1] = 8'hF0;
      prog[2] = 8'h78; prog[3] = 8'h20;
      prog[4] = 8'h16;
      do_reset(1'b0);
      wait_writes(2, 40, "mid_wb");
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({rf_write_enable, carry_flag} !== 2'b11) begin
         failures++;
         $display("FAIL mid_wb_precondition: we/carry=%b%b required 11", rf_write_enable, carry_flag);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({rf_write_enable, pc_write_enable, carry_flag, zero_flag} !== 4'b0) begin
         failures++;
         $display("FAIL mid_wb_drop: we/pcwe/c/z=%b required 0000",
                  {rf_write_enable, pc_write_enable, carry_flag, zero_flag});
      end
      @(posedge clk); #1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({imem_req, imem_addr, regs[1]} !== {1'b1, 8'h00, 8'hF0}) begin
         failures++;
         $display("FAIL mid_wb_after: req/addr/r1=%b/%h/%h required 1/00/f0",
                  imem_req, imem_addr, regs[1]);
      end
   endtask

   task automatic test_sub();
      clear_prog();
      prog[0] = 8'h70; prog[1] = 8'h05;   // LDI R0,5
      prog[2] = 8'h7C; prog[3] = 8'h05;   // LDI R3,5
      prog[4] = 8'h23; prog[5] = 8'h23;   // SUB R0,R3 twice
      do_reset(1'b0);
      wait_writes(3, 60, "sub_zero");
      checks++;
      if ({wr_addr_log[2], wr_data_log[2], carry_flag, zero_flag} !== {2'd0, 8'h00, 2'b01}) begin
         failures++;
         $display("FAIL sub_zero: addr/data/c/z=%0d/%h/%b%b required 0/00/01",
                  wr_addr_log[2], wr_data_log[2], carry_flag, zero_flag);
      end
      wait_writes(4, 20, "sub_borrow");
      checks++;
      if ({wr_addr_log[3], wr_data_log[3], carry_flag, zero_flag} !== {2'd0, 8'hFB, 2'b10}) begin
         failures++;
         $display("FAIL sub_borrow: addr/data/c/z=%0d/%h/%b%b required 0/fb/10",
                  wr_addr_log[3], wr_data_log[3], carry_flag, zero_flag);
      end
      run_to_halt(20, "sub");
      checks++;
      if ({regs[0], regs[3]} !== 16'hFB05) begin
         failures++;
         $display("FAIL sub_regs: r0r3=%h required fb05", {regs[0], regs[3]});
      end
   endtask

   task automatic test_wait_states();
      logic stable = 1'b1;
      clear_prog();
      prog[0] = 8'h69;                    // MOV R2,R1
      preset[0] = 8'h11; preset[1] = 8'h3C; preset[2] = 8'h00; preset[3] = 8'h77;
      wait_cfg = 3;
      do_reset(1'b1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         if ({imem_req, imem_addr, rf_read_addr1, rf_read_addr2} !== {1'b1, 8'h00, 4'b0000})
            stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) begin
         failures++;
         $display("FAIL wait_addr_stable: got %b required 1", stable);
      end
      @(negedge clk); #1;
      checks++;
      if ({rf_read_addr1, rf_read_addr2, pc_write_enable} !== {2'd2, 2'd1, 1'b1}) begin
         failures++;
         $display("FAIL wait_ir_latch: rd/rs/pcwe=%0d/%0d/%b required 2/1/1",
                  rf_read_addr1, rf_read_addr2, pc_write_enable);
      end
      wait_writes(1, 20, "wait_mov");
      checks++;
      if ({wr_addr_log[0], wr_data_log[0]} !== {2'd2, 8'h3C} || wr_cyc_log[0] != 6) begin
         failures++;
         $display("FAIL wait_mov_write: addr/data/cyc=%0d/%h/%0d required 2/3c/6",
                  wr_addr_log[0], wr_data_log[0], wr_cyc_log[0]);
      end
      run_to_halt(40, "wait");
      checks++;
      if ({carry_flag, zero_flag, regs[2]} !== {2'b00, 8'h3C}) begin
         failures++;
         $display("FAIL wait_mov_final: c/z/r2=%b%b/%h required 00/3c", carry_flag, zero_flag, regs[2]);
      end
      wait_cfg = 0;
   endtask

   task automatic test_reserved_halt();
      int req0, pulse0;
      clear_prog();
      prog[0] = 8'h70; prog[1] = 8'hFF;   // LDI R0,0xFF
      prog[2] = 8'h74; prog[3] = 8'h01;   // LDI R1,0x01
      prog[4] = 8'h11;                    // ADD R0,R1
      prog[5] = 8'hA5;                    // reserved
      do_reset(1'b0);
      wait_writes(3, 60, "resv_add");
      checks++;
      if ({wr_data_log[2], carry_flag, zero_flag} !== {8'h00, 2'b11}) begin
         failures++;
         $display("FAIL resv_add_wrap: data/c/z=%h/%b%b required 00/11",
                  wr_data_log[2], carry_flag, zero_flag);
      end
      run_to_halt(30, "resv");
      checks++;
      if (wr_count != 3 || {carry_flag, zero_flag, regs[1]} !== {2'b11, 8'h01}) begin
         failures++;
         $display("FAIL resv_no_effect: writes/cz/r1=%0d/%b%b/%h required 3/11/01",
                  wr_count, carry_flag, zero_flag, regs[1]);
      end
      checks++;
      if (pc_pulses != 7 || halt_cyc != 16) begin
         failures++;
         $display("FAIL resv_timing: pulses/halt_cyc=%0d/%0d required 7/16", pc_pulses, halt_cyc);
      end
      req0 = req_count; pulse0 = pc_pulses;
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if (req_count != req0 || pc_pulses != pulse0 || wr_count != 3 || halted !== 1'b1) begin
         failures++;
         $display("FAIL halt_quiet: req %0d->%0d pulses %0d->%0d writes=%0d halted=%b required no change/3/1",
                  req0, req_count, pulse0, pc_pulses, wr_count, halted);
      end
   endtask

   task automatic test_valid_ignored();
      clear_prog();
      prog[0] = 8'h56;                    // XOR R1,R2
      preset[0] = 8'h00; preset[1] = 8'h0F; preset[2] = 8'h3C; preset[3] = 8'h00;
      do_reset(1'b1);
      @(posedge clk); #1 inject = 1'b1;   // now in DECODE
      @(posedge clk); #1;                 // now in EXECUTE
      checks++;
      if ({rf_read_addr1, rf_read_addr2} !== {2'd1, 2'd2}) begin
         failures++;
         $display("FAIL ignore_decode: rd/rs=%0d/%0d required 1/2", rf_read_addr1, rf_read_addr2);
      end
      @(posedge clk); #1 inject = 1'b0;   // now in WRITEBACK
      checks++;
      if ({rf_read_addr1, rf_read_addr2, rf_write_enable, pc_write_enable, rf_write_data} !==
          {2'd1, 2'd2, 1'b1, 1'b0, 8'h33}) begin
         failures++;
         $display("FAIL ignore_execute: rd/rs/we/pcwe/data=%0d/%0d/%b/%b/%h required 1/2/1/0/33",
                  rf_read_addr1, rf_read_addr2, rf_write_enable, pc_write_enable, rf_write_data);
      end
      run_to_halt(20, "ignore");
      checks++;
      if (pc_pulses != 2 || regs[1] !== 8'h33 || {carry_flag, zero_flag} !== 2'b00) begin
         failures++;
         $display("FAIL ignore_final: pulses/r1/cz=%0d/%h/%b%b required 2/33/00",
                  pc_pulses, regs[1], carry_flag, zero_flag);
      end
   endtask

   initial begin
      test_reset();
      test_ldi_add();
      test_reset_mid_wb();
      test_sub();
      test_wait_states();
      test_reserved_halt();
      test_valid_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
